// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types for the key event queue
package calc_pkg;
    localparam int NUM_KEYS = 5;
    localparam int KEY_W    = $clog2(NUM_KEYS);

    typedef logic [KEY_W-1:0] key_idx_t;

    typedef struct packed {
        key_idx_t key;
        logic     is_repeat;
    } key_event_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } hold_state_t;
endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - power-of-two event FIFO with valid/ready head and full/empty flags
module event_fifo
    import calc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  key_event_t i_push_data,
    input  logic       i_ready,
    output logic       o_valid,
    output key_event_t o_data,
    output logic       o_full,
    output logic       o_empty
);
    localparam int             PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

    key_event_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == COUNT_FULL);
    assign o_valid = !o_empty;
    // Head is forced to zero when empty so the outputs read 0 throughout reset
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign w_pop   = o_valid && i_ready;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/key_event_queue.sv
// rtl/key_event_queue.sv - key press edge detect, press/repeat arbiter and hold FSM feeding an event FIFO
module key_event_queue #(
    parameter int NUM_KEYS      = 5,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_KEYS-1:0]         deb,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [$clog2(NUM_KEYS)-1:0] ev_key,
    output logic                        ev_repeat,
    output logic                        ovf
);
    import calc_pkg::*;

    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [NUM_KEYS-1:0] r_deb_q;
    logic [NUM_KEYS-1:0] r_pending;
    logic [NUM_KEYS-1:0] w_rise;
    logic [NUM_KEYS-1:0] w_clr;
    hold_state_t         r_state;
    hold_state_t         w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    key_idx_t            r_active;
    key_idx_t            w_active_next;
    key_idx_t            w_press_key;
    logic                r_rep_req;
    logic                w_rep_req_next;
    logic                w_press_any;
    logic                w_can_push;
    logic                w_press_enq;
    logic                w_rep_enq;
    logic                w_rep_drop;
    logic                w_release;
    logic                w_fire;
    logic                w_push;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_fifo_valid;
    key_event_t          w_push_data;
    key_event_t          w_head;

    assign w_rise = deb & ~r_deb_q;

    always_comb begin
        w_press_any = 1'b0;
        w_press_key = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_press_any = 1'b1;
                w_press_key = key_idx_t'(i);
            end
        end
    end

    assign w_can_push  = !w_fifo_full || (!w_fifo_empty && ev_ready);
    assign w_release   = (r_state != ST_IDLE) && !deb[r_active];
    assign w_press_enq = w_press_any && w_can_push;
    // A repeat request seen in the release cycle is stale and is neither queued nor counted as lost
    assign w_rep_enq   = !w_press_any && r_rep_req && !w_release && w_can_push;
    assign w_rep_drop  = !w_press_any && r_rep_req && !w_release && !w_can_push;
    assign w_push      = w_press_enq || w_rep_enq;
    assign w_push_data = w_press_enq ? key_event_t'({w_press_key, 1'b0})
                                     : key_event_t'({r_active, 1'b1});
    assign w_clr       = w_press_enq ? (NUM_KEYS'(1) << w_press_key) : '0;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_active_next = r_active;
        w_fire        = 1'b0;
        if (w_press_enq) begin
            w_state_next  = ST_HOLD;
            w_cnt_next    = '0;
            w_active_next = w_press_key;
        end else begin
            case (r_state)
                ST_HOLD, ST_REPEAT: begin
                    if (w_release) begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end else if (r_cnt == ((r_state == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
                        w_fire       = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = ST_REPEAT;
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end

        w_rep_req_next = r_rep_req;
        if (w_release) begin
            w_rep_req_next = 1'b0;
        end else if (w_fire) begin
            w_rep_req_next = 1'b1;
        end else if (w_rep_enq || w_rep_drop) begin
            w_rep_req_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_q   <= '0;
            r_pending <= '0;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_active  <= '0;
            r_rep_req <= 1'b0;
        end else begin
            r_deb_q   <= deb;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_active  <= w_active_next;
            r_rep_req <= w_rep_req_next;
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_ready     (ev_ready),
        .o_valid     (w_fifo_valid),
        .o_data      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign ev_valid  = w_fifo_valid;
    assign ev_key    = w_head.key;
    assign ev_repeat = w_head.is_repeat;
    assign ovf       = w_rep_drop;
endmodule

// File: tb/tb_key_event_queue.sv
// tb/tb_key_event_queue.sv - self-checking bench for key_event_queue
module tb_key_event_queue;
    localparam int NK    = 5;
    localparam int HOLD  = 8;
    localparam int REP   = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] deb;
    logic          ev_ready;
    logic          ev_valid;
    logic [2:0]    ev_key;
    logic          ev_repeat;
    logic          ovf;

    key_event_queue #(
        .NUM_KEYS      (NK),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .deb       (deb),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_key    (ev_key),
        .ev_repeat (ev_repeat),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_ovf    = 0;

    typedef struct { int key; bit rep; } mev_t;
    typedef struct { int c; int key; bit rep; } obs_t;
    typedef struct {
        logic [NK-1:0] deb;
        logic          rdy;
        logic          v;
        int            key;
        logic          rep;
        logic          ovf;
    } vec_t;

    // Behavioural reference: event list, pending presses, and a hold timer counted in cycles
    mev_t          mq[$];
    obs_t          obs[$];
    bit [NK-1:0]   m_prev;
    bit [NK-1:0]   m_pend;
    bit            m_track;
    bit            m_repeating;
    bit            m_req;
    int            m_key;
    int            m_age;

    logic          s_valid;
    logic [2:0]    s_key;
    logic          s_rep;
    logic          s_ovf;
    logic [NK-1:0] rd;
    logic          rr;
    vec_t          tbl[10];
    int            t0;
    int            e39[6];
    int            e40[6];
    int            e41[4];
    int            ovf_base;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void model_reset();
        mq.delete();
        m_prev = '0; m_pend = '0;
        m_track = 0; m_repeating = 0; m_req = 0;
        m_key = 0; m_age = 0;
    endfunction

    function automatic void model_step(input bit [NK-1:0] d, input bit rdy, output bit drop);
        bit pop, room, released, press, rep_go, fire;
        int p;
        pop  = (mq.size() > 0) && rdy;
        room = (mq.size() < DEPTH) || pop;
        p = -1;
        for (int i = 0; i < NK; i++) if (m_pend[i] && p < 0) p = i;
        released = m_track && !d[m_key];
        press    = (p >= 0) && room;
        rep_go   = (p < 0) && m_req && !released && room;
        drop     = (p < 0) && m_req && !released && !room;
        if (pop) void'(mq.pop_front());
        if (press) mq.push_back('{p, 1'b0});
        else if (rep_go) mq.push_back('{m_key, 1'b1});
        fire = 0;
        if (press) begin
            m_track = 1; m_repeating = 0; m_key = p; m_age = 0;
        end else if (released) begin
            m_track = 0;
        end else if (m_track) begin
            if (m_age == (m_repeating ? REP : HOLD) - 1) begin
                fire = 1; m_repeating = 1; m_age = 0;
            end else begin
                m_age++;
            end
        end
        if (released) m_req = 0;
        else if (fire) m_req = 1;
        else if (rep_go || drop) m_req = 0;
        if (press) m_pend[p] = 0;
        m_pend = m_pend | (d & ~m_prev);
        m_prev = d;
    endfunction

    // Called just after a rising edge: drive, sample at negedge, check against the model
    task automatic step(input logic [NK-1:0] d, input logic rdy);
        bit drop;
        deb = d;
        ev_ready = rdy;
        @(negedge clk);
        s_valid = ev_valid; s_key = ev_key; s_rep = ev_repeat; s_ovf = ovf;
        if (!rst_n) begin
            chk("rst_valid", ev_valid, 0);
            chk("rst_key", ev_key, 0);
            chk("rst_repeat", ev_repeat, 0);
            chk("rst_ovf", ovf, 0);
            model_reset();
        end else begin
            chk("model_valid", ev_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("model_key", ev_key, mq[0].key);
                chk("model_repeat", ev_repeat, mq[0].rep);
            end
            model_step(d, rdy, drop);
            chk("model_ovf", ovf, drop);
        end
        if (rst_n && ev_valid && rdy) obs.push_back('{cyc, int'(ev_key), ev_repeat});
        if (ovf) n_ovf++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{5'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[1] = '{5'h04, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[2] = '{5'h04, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[3] = '{5'h04, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        tbl[4] = '{5'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[5] = '{5'h0A, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[6] = '{5'h0A, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[7] = '{5'h0A, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        tbl[8] = '{5'h0A, 1'b1, 1'b1, 3, 1'b0, 1'b0};
        tbl[9] = '{5'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        e39 = '{2, 11, 15, 19, 23, 27};
        e40 = '{0, 1, 2, 3, 0, 4};
        e41 = '{1, 2, 3, 0};
        model_reset();

        rst_n = 1'b0; deb = '0; ev_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(5'h00, 1'b0);
        step(5'h15, 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].deb, tbl[i].rdy);
            chk($sformatf("vec%0d_valid", i), s_valid, tbl[i].v);
            if (tbl[i].v) begin
                chk($sformatf("vec%0d_key", i), s_key, tbl[i].key);
                chk($sformatf("vec%0d_repeat", i), s_rep, tbl[i].rep);
            end
            chk($sformatf("vec%0d_ovf", i), s_ovf, tbl[i].ovf);
        end

        // Held key: one press, first repeat after the hold time, then at the repeat period
        repeat (3) step(5'h00, 1'b1);
        obs.delete();
        t0 = cyc;
        repeat (30) step(5'h01, 1'b1);
        repeat (12) step(5'h00, 1'b1);
        chk("hold_event_count", obs.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < obs.size()) begin
                chk($sformatf("hold_ev%0d_time", i), obs[i].c - t0, e39[i]);
                chk($sformatf("hold_ev%0d_key", i), obs[i].key, 0);
                chk($sformatf("hold_ev%0d_repeat", i), obs[i].rep, (i != 0) ? 1 : 0);
            end
        end

        // Six presses against a stalled consumer: four queued, two held pending
        repeat (2) step(5'h00, 1'b1);
        obs.delete();
        ovf_base = n_ovf;
        step(5'h1F, 1'b0);
        repeat (5) step(5'h00, 1'b0);
        step(5'h01, 1'b0);
        repeat (3) step(5'h00, 1'b0);
        chk("stall_head_valid", s_valid, 1);
        chk("stall_head_key", s_key, 0);
        repeat (10) step(5'h00, 1'b1);
        chk("stall_event_count", obs.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < obs.size()) begin
                chk($sformatf("stall_ev%0d_key", i), obs[i].key, e40[i]);
                chk($sformatf("stall_ev%0d_repeat", i), obs[i].rep, 0);
            end
        end
        chk("stall_no_ovf", n_ovf - ovf_base, 0);

        // Full queue while key 0 auto-repeats: each repeat is dropped with an ovf pulse
        repeat (2) step(5'h00, 1'b1);
        obs.delete();
        ovf_base = n_ovf;
        step(5'h0E, 1'b0);
        repeat (4) step(5'h00, 1'b0);
        repeat (24) step(5'h01, 1'b0);
        repeat (4) step(5'h00, 1'b0);
        chk("full_ovf_pulses", n_ovf - ovf_base, 4);
        repeat (8) step(5'h00, 1'b1);
        chk("full_event_count", obs.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs.size()) begin
                chk($sformatf("full_ev%0d_key", i), obs[i].key, e41[i]);
                chk($sformatf("full_ev%0d_repeat", i), obs[i].rep, 0);
            end
        end

        // Asynchronous reset with three events queued; held keys re-press once after release
        repeat (3) step(5'h00, 1'b1);
        repeat (5) step(5'h07, 1'b0);
        chk("pre_reset_valid", ev_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", ev_valid, 0);
        chk("async_reset_key", ev_key, 0);
        model_reset();
        #1;
        step(5'h07, 1'b0);
        step(5'h07, 1'b1);
        rst_n = 1'b1;
        obs.delete();
        repeat (4) step(5'h07, 1'b1);
        repeat (8) step(5'h00, 1'b1);
        chk("post_reset_count", obs.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < obs.size()) begin
                chk($sformatf("post_reset_ev%0d_key", i), obs[i].key, i);
                chk($sformatf("post_reset_ev%0d_repeat", i), obs[i].rep, 0);
            end
        end

        // Random key activity and consumer backpressure against the reference model
        rd = '0;
        rr = 1'b1;
        for (int c = 0; c < 900; c++) begin
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, 11) == 0) rd[k] = ~rd[k];
            end
            if ($urandom_range(0, 15) == 0) rr = ~rr;
            step(rd, rr && ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
